id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Decode and operand-fetch stage sitting directly upstream of the 64-bit, 32-entry register file `rf`. It takes one RV64I-subset instruction per handshake, drives the read-port numbers, and captures the two operands with write-back bypass into an output pipeline register. It also captures the sign-extended immediate and control fields, and inserts a single bubble on a load-use hazard.

## Interface
- `XLEN`, 64, operand/immediate width (matches `rf` data width)
- `NREG_W`, 5, register-number width (32 registers)
- `clk` in 1: rising-edge clock, shared with `rf`
- `reset` in 1: asynchronous, active-high; clears all state
- `in_valid` in 1: upstream instruction valid
- `in_instr` in 32: instruction word
- `in_ready` out 1: stage accepts `in_instr` this cycle
- `regRNum1` out NREG_W: rf read port 1 number = `in_instr[19:15]` (combinational)
- `regRNum2` out NREG_W: rf read port 2 number = `in_instr[24:20]` (combinational)
- `rData1`, `rData2` in XLEN: rf read data (combinational read)
- `wb_we` in 1, `wb_reg` in NREG_W, `wb_data` in XLEN: same signals driving rf `RegWrite`/`wReg`/`data`
- `out_valid` out 1, `out_ready` in 1: downstream handshake
- `out_op` out 3: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 7 ILLEGAL
- `out_funct` out 4: {instr[30], instr[14:12]}
- `out_rd` out NREG_W, `out_rs1val`/`out_rs2val` out XLEN, `out_imm` out XLEN

## Operation
- Opcode decode: 0110011 ALU_R; 0010011 ALU_I; 0000011 LOAD; 0100011 STORE; 1100011 BRANCH; any other ILLEGAL.
- Immediates, sign-extended to XLEN:
  - I-type (ALU_I, LOAD): instr[31:20]
  - S-type: {instr[31:25], instr[11:7]}
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - ALU_R and ILLEGAL: 0
- `out_rd` = instr[11:7] for ALU_R/ALU_I/LOAD; 0 otherwise.
- Source use: rs1 is used by all legal ops. rs2 is used by ALU_R, STORE and BRANCH only.
- Operand select per source, in priority order:
  - register 0 gives 0;
  - else `wb_we` && `wb_reg`==rs gives `wb_data` (write-through bypass);
  - else the rf read data.
- Load-use hazard (`haz`): `out_valid` && `out_op`==LOAD && `out_rd`!=0 && `out_rd` matches a used source of `in_instr` && `in_valid`. ILLEGAL never raises `haz`.
- `adv` = !`out_valid` || `out_ready`.
- `in_ready` = `adv` && !`haz`.
- On each clock edge with `adv`=1:
  - `out_valid` <= `in_valid` && !`haz`;
  - payload registers load from the decode/operand path.
- On a clock edge with `adv`=0, all output registers hold.
- ILLEGAL instructions pass through with `out_op`=7, operands still fetched, and `out_imm`=0.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): `out_valid`=0 and all payload outputs 0. An instruction held mid-stall is discarded.
- Latency is 1 cycle: the instruction is accepted at edge N and visible at the outputs after edge N.
- Throughput is 1 per cycle when `out_ready`=1 and there is no hazard.
- Hazard inserts exactly one bubble:
  - the load transfers while `in_ready`=0 and `out_valid` goes to 0;
  - the consumer is accepted on the next cycle.
- Bypass covers a write and a read of the same register in the same cycle. `out_rs*val` equals the value rf holds after that edge.
- `out_valid`=1 with `out_ready`=0: payload stable and `in_ready`=0 until transfer.
- Simultaneous transfer out and accept in (full pipe, `out_ready`=1) is legal with no bubble.
- `regRNum1`/`regRNum2` always track `in_instr`, regardless of `in_valid`.

## Test plan
All scenarios start from rf preloaded with reg[k]=k*10.
- `add x3,x1,x2` (0x002081B3), `out_ready`=1 → next cycle `out_valid`=1, `out_op`=0, `out_rd`=3, `out_rs1val`=10, `out_rs2val`=20, `out_imm`=0.
- `addi x7,x0,-1` (0xFFF00393) → `out_op`=1, `out_rs1val`=0, `out_imm`=0xFFFF_FFFF_FFFF_FFFF, `out_rd`=7.
- Same cycle as accepting 0x002081B3, drive `wb_we`=1, `wb_reg`=2, `wb_data`=999 → `out_rs2val`=999, `out_rs1val`=10.
- `ld x5,8(x4)` (0x00823283) then `add x6,x5,x1` (0x00128333) back to back, with `out_ready`=1:
  - `in_ready`=0 for one cycle and one `out_valid`=0 bubble;
  - then add with `out_rs1val` = the `wb_data` for reg 5 if written that cycle, else 50.
- Hold `out_ready`=0 for 3 cycles with `out_valid`=1 → payload unchanged and `in_ready`=0; release → next instruction flows with no loss or duplication.
- Assert `reset` mid-stall → `out_valid` goes to 0 immediately (asynchronously), all outputs 0; opcode 0x7F afterward → `out_op`=7.

Source files
------------

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - RV64I-subset decode and operand fetch stage with write-back bypass
//
// Purpose: decodes one instruction per handshake, drives the register-file read
// port numbers, selects operands (x0 / write-back bypass / rf data) and captures
// decoded fields into an output pipeline register. A load followed directly by a
// consumer of its destination costs exactly one bubble.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid, in_instr, in_ready   upstream instruction handshake
//   regRNum1, regRNum2             rf read port numbers (rs1, rs2 fields of in_instr)
//   rData1, rData2                 rf combinational read data
//   wb_we, wb_reg, wb_data         write-back port, also feeds the bypass
//   out_valid, out_ready           downstream handshake
//   out_op, out_funct, out_rd      decoded op class, {instr[30], funct3}, destination
//   out_rs1val, out_rs2val,out_imm operands and sign-extended immediate
module id_operand_stage #(
    parameter int XLEN   = 64,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic [NREG_W-1:0] regRNum1,
    output logic [NREG_W-1:0] regRNum2,
    input  logic [XLEN-1:0]   rData1,
    input  logic [XLEN-1:0]   rData2,
    input  logic              wb_we,
    input  logic [NREG_W-1:0] wb_reg,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_op,
    output logic [3:0]        out_funct,
    output logic [NREG_W-1:0] out_rd,
    output logic [XLEN-1:0]   out_rs1val,
    output logic [XLEN-1:0]   out_rs2val,
    output logic [XLEN-1:0]   out_imm
);

    typedef enum logic [2:0] {
        OpAluR    = 3'd0,
        OpAluI    = 3'd1,
        OpLoad    = 3'd2,
        OpStore   = 3'd3,
        OpBranch  = 3'd4,
        OpIllegal = 3'd7
    } op_e;

    op_e               decOp;
    logic [XLEN-1:0]   decImm;
    logic [NREG_W-1:0] decRd;
    logic              usesRs1;
    logic              usesRs2;
    logic [XLEN-1:0]   opnd1;
    logic [XLEN-1:0]   opnd2;
    logic              haz;
    logic              adv;

    // Read ports follow the instruction word unconditionally; rf data is combinational.
    assign regRNum1 = NREG_W'(in_instr[19:15]);
    assign regRNum2 = NREG_W'(in_instr[24:20]);

    always_comb begin
        decOp   = OpIllegal;
        decImm  = '0;
        decRd   = '0;
        usesRs1 = 1'b1;
        usesRs2 = 1'b0;
        unique case (in_instr[6:0])
            7'b0110011: begin
                decOp   = OpAluR;
                decRd   = NREG_W'(in_instr[11:7]);
                usesRs2 = 1'b1;
            end
            7'b0010011: begin
                decOp  = OpAluI;
                decRd  = NREG_W'(in_instr[11:7]);
                decImm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end
            7'b0000011: begin
                decOp  = OpLoad;
                decRd  = NREG_W'(in_instr[11:7]);
                decImm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                decOp   = OpStore;
                usesRs2 = 1'b1;
                decImm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                decOp   = OpBranch;
                usesRs2 = 1'b1;
                decImm  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            default: begin
                // Illegal ops never stall, so they claim no sources for hazard purposes.
                usesRs1 = 1'b0;
            end
        endcase
    end

    // x0 reads as zero; a same-cycle write-back wins over the stale rf read data.
    function automatic logic [XLEN-1:0] selOperand(
        input logic [NREG_W-1:0] rs,
        input logic [XLEN-1:0]   rfData,
        input logic              we,
        input logic [NREG_W-1:0] wReg,
        input logic [XLEN-1:0]   wData
    );
        if (rs == '0)
            return '0;
        else if (we && (wReg == rs))
            return wData;
        else
            return rfData;
    endfunction

    assign opnd1 = selOperand(regRNum1, rData1, wb_we, wb_reg, wb_data);
    assign opnd2 = selOperand(regRNum2, rData2, wb_we, wb_reg, wb_data);

    // The load result only reaches write-back after the load leaves this stage, so a
    // dependent instruction right behind it must wait one cycle.
    assign haz = in_valid && out_valid && (out_op == OpLoad) && (out_rd != '0) &&
                 ((usesRs1 && (out_rd == regRNum1)) || (usesRs2 && (out_rd == regRNum2)));

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !haz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_funct  <= '0;
            out_rd     <= '0;
            out_rs1val <= '0;
            out_rs2val <= '0;
            out_imm    <= '0;
        end else if (adv) begin
            out_valid  <= in_valid && !haz;
            out_op     <= decOp;
            out_funct  <= {in_instr[30], in_instr[14:12]};
            out_rd     <= decRd;
            out_rs1val <= opnd1;
            out_rs2val <= opnd2;
            out_imm    <= decImm;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - scoreboard testbench for id_operand_stage
module tb_id_operand_stage;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [4:0]  regRNum1;
    logic [4:0]  regRNum2;
    logic [63:0] rData1;
    logic [63:0] rData2;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [3:0]  out_funct;
    logic [4:0]  out_rd;
    logic [63:0] out_rs1val;
    logic [63:0] out_rs2val;
    logic [63:0] out_imm;

    logic [63:0] rf [32];
    exp_t        q[$];
    exp_t        dutOut;
    int          checks;
    int          failures;

    id_operand_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .regRNum1(regRNum1), .regRNum2(regRNum2),
        .rData1(rData1), .rData2(rData2),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_funct(out_funct), .out_rd(out_rd),
        .out_rs1val(out_rs1val), .out_rs2val(out_rs2val), .out_imm(out_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: preloaded with reg[k] = k*10, written at the clock edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) rf[k] <= 64'(k * 10);
        end else if (wb_we) begin
            rf[wb_reg] <= wb_data;
        end
    end
    assign rData1 = rf[regRNum1];
    assign rData2 = rf[regRNum2];

    assign dutOut = {out_op, out_funct, out_rd, out_rs1val, out_rs2val, out_imm};

    function automatic exp_t mk(input logic [2:0] op, input logic [3:0] funct, input logic [4:0] rd,
                                input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
        exp_t e;
        e.op = op; e.funct = funct; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chkOut(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got op=%0d funct=%0d rd=%0d rs1=%0h rs2=%0h imm=%0h want op=%0d funct=%0d rd=%0d rs1=%0h rs2=%0h imm=%0h",
                     name, got.op, got.funct, got.rd, got.rs1, got.rs2, got.imm,
                     want.op, want.funct, want.rd, want.rs1, want.rs2, want.imm);
        end
    endtask

    // Drive one instruction until accepted; the expected result is queued at acceptance.
    task automatic issue(input logic [31:0] instr, input exp_t e, output int waits);
        bit done;
        in_valid = 1'b1;
        in_instr = instr;
        waits = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1;
            end else begin
                waits++;
                if (waits > 20) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout instr=%08h got in_ready=0 want 1", instr);
                    done = 1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every output transfer is compared against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected got op=%0d rd=%0d want no output", out_op, out_rd);
                end else begin
                    e = q.pop_front();
                    chkOut("out_payload", dutOut, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        int   w;
        exp_t expSw;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'h0;
        wb_we    = 1'b0;
        wb_reg   = 5'd0;
        wb_data  = 64'd0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        in_instr = 32'h00128333;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_payload", 64'(|dutOut), 64'd0);
        chk("regRNum1_track", 64'(regRNum1), 64'd5);
        chk("regRNum2_track", 64'(regRNum2), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back flow: add, addi, add with write-through bypass on x2.
        issue(32'h002081B3, mk(3'd0, 4'd0, 5'd3, 64'd10, 64'd20, 64'd0), w);
        issue(32'hFFF00393, mk(3'd1, 4'd8, 5'd7, 64'd0, 64'd310, 64'hFFFF_FFFF_FFFF_FFFF), w);
        chk("throughput_wait", 64'(w), 64'd0);
        wb_we = 1'b1; wb_reg = 5'd2; wb_data = 64'd999;
        issue(32'h002081B3, mk(3'd0, 4'd0, 5'd3, 64'd10, 64'd999, 64'd0), w);
        wb_we = 1'b0;

        // Load-use: ld x5,8(x4) then add x6,x5,x1; x5 written back during the bubble.
        issue(32'h00823283, mk(3'd2, 4'd3, 5'd5, 64'd40, 64'd80, 64'd8), w);
        in_valid = 1'b1;
        in_instr = 32'h00128333;
        @(negedge clk);
        chk("haz_in_ready", 64'(in_ready), 64'd0);
        chk("haz_load_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        wb_we = 1'b1; wb_reg = 5'd5; wb_data = 64'd777;
        @(negedge clk);
        chk("haz_bubble", 64'(out_valid), 64'd0);
        chk("haz_accept", 64'(in_ready), 64'd1);
        if (in_ready) q.push_back(mk(3'd0, 4'd0, 5'd6, 64'd777, 64'd10, 64'd0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_we = 1'b0;

        // Stall: sw x3,12(x1) held for 3 cycles while beq x1,x3,-4 waits upstream.
        expSw = mk(3'd3, 4'd2, 5'd0, 64'd10, 64'd30, 64'd12);
        issue(32'h0030A623, expSw, w);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'hFE308EE3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chkOut("stall_payload", dutOut, expSw);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) q.push_back(mk(3'd4, 4'd8, 5'd0, 64'd10, 64'd30, 64'hFFFF_FFFF_FFFF_FFFC));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted mid-stall discards the held instruction immediately.
        out_ready = 1'b0;
        issue(32'h00128333, mk(3'd0, 4'd0, 5'd6, 64'd777, 64'd10, 64'd0), w);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_payload", 64'(|dutOut), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        issue(32'h0000007F, mk(3'd7, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0), w);

        for (int c = 0; c < 10 && q.size() != 0; c++) @(negedge clk);
        chk("drain_queue_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
